ring_counter_param: RTL and testbench

Parametrised ring/shift pattern generator, successor to the fixed 18-bit bidirectional ring counter used for LED-chaser and one-hot sequencing in the base counter library. Adds configurable width and reset pattern, four operating modes (ring, Johnson, bounce, hold), a step prescaler, parallel load, and a home-return pulse. Sits between board switches/control logic and LED or one-hot select outputs.

---
 rtl/ring_counter_param_if.sv | 28 ++
 rtl/ring_counter_param.sv | 109 ++++++++++
 tb/tb_ring_counter_param.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ring_counter_param_if.sv
// Control and pattern bus of the parametrised ring/shift pattern generator.
// The master side drives the step controls and reads the pattern back.
interface ring_counter_param_if #(
  parameter int WIDTH   = 18,
  parameter int PRESC_W = 8
) ();

  logic               en;
  logic               sw;
  logic [1:0]         mode;
  logic [PRESC_W-1:0] presc;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   OUT;
  logic               wrap;
  logic               dir_o;

  modport master (
    output en, sw, mode, presc, load, load_val,
    input  OUT, wrap, dir_o
  );

  modport slave (
    input  en, sw, mode, presc, load, load_val,
    output OUT, wrap, dir_o
  );

endinterface

// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson / bounce pattern generator with step
// prescaler, parallel load and a pulse on return to the home pattern.
module ring_counter_param #(
  parameter int               WIDTH   = 18,
  parameter logic [WIDTH-1:0] INIT    = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               PRESC_W = 8
) (
  input logic                 clk,
  input logic                 res,
  ring_counter_param_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_RING    = 2'b00,
    MODE_JOHNSON = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  mode_e              mode;
  logic [WIDTH-1:0]   out_q;
  logic [WIDTH-1:0]   home_q;
  logic [PRESC_W-1:0] cnt_q;
  logic               wrap_q;
  logic               bdir_q;

  logic               advance;
  logic               fire;
  logic [WIDTH-1:0]   step_out;
  logic               step_bdir;

  assign mode = mode_e'(bus.mode);

  // The prescaler only runs while enabled and not held; a presc lowered
  // below the current count fires on the next enabled cycle.
  assign advance = bus.en && (mode != MODE_HOLD);
  assign fire    = advance && (cnt_q >= bus.presc);

  // Candidate pattern and bounce direction if a step fires this cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    step_out  = out_q;
    step_bdir = bdir_q;
    case (mode)
      MODE_RING: begin
        step_out = bus.sw ? {out_q[WIDTH-2:0], out_q[WIDTH-1]}
                          : {out_q[0], out_q[WIDTH-1:1]};
      end
      MODE_JOHNSON: begin
        step_out = bus.sw ? {out_q[WIDTH-2:0], ~out_q[WIDTH-1]}
                          : {~out_q[0], out_q[WIDTH-1:1]};
      end
      MODE_BOUNCE: begin
        // Hitting an end reverses direction and the same step moves away
        // from it; an all-zero pattern simply stays zero.
        if (bdir_q && out_q[WIDTH-1]) begin
          step_out  = out_q >> 1;
          step_bdir = 1'b0;
        end else if (!bdir_q && out_q[0]) begin
          step_out  = out_q << 1;
          step_bdir = 1'b1;
        end else begin
          step_out = bdir_q ? (out_q << 1) : (out_q >> 1);
        end
      end
      default: step_out = out_q;
    endcase
  end

  // Pattern, home, prescaler, wrap pulse and bounce direction registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (res) begin
      out_q  <= INIT;
      home_q <= INIT;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      bdir_q <= bus.sw;
    end else if (bus.load) begin
      out_q  <= bus.load_val;
      home_q <= bus.load_val;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      bdir_q <= bus.sw;
    end else begin
      wrap_q <= fire && (step_out == home_q);
      if (advance) begin
        cnt_q <= fire ? '0 : cnt_q + PRESC_W'(1);
      end
      if (fire) begin
        out_q <= step_out;
      end
      // Bounce latches its own direction; ring/Johnson follow sw so that
      // entering bounce starts from the last sampled sw; hold freezes it.
      if (mode == MODE_BOUNCE) begin
        if (fire) begin
          bdir_q <= step_bdir;
        end
      end else if (mode != MODE_HOLD) begin
        bdir_q <= bus.sw;
      end
    end
  end

  assign bus.OUT   = out_q;
  assign bus.wrap  = wrap_q;
  assign bus.dir_o = (mode == MODE_BOUNCE) ? bdir_q : bus.sw;

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed bench for ring_counter_param (WIDTH=18, INIT=1, PRESC_W=8):
// a vector table for single-edge behaviour plus hand-written multi-step runs.
module tb_ring_counter_param;

  localparam int WIDTH   = 18;
  localparam int PRESC_W = 8;

  logic clk;
  logic res;

  ring_counter_param_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  ring_counter_param #(
    .WIDTH  (WIDTH),
    .INIT   (18'h00001),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        res;
    logic        load;
    logic [17:0] load_val;
    logic        en;
    logic        sw;
    logic [1:0]  mode;
    logic [7:0]  presc;
    logic [17:0] exp_out;
    logic        exp_wrap;
    logic        exp_dir;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic ld, input logic [17:0] lv,
                       input logic e, input logic s, input logic [1:0] m,
                       input logic [7:0] p);
    res          = r;
    bus.load     = ld;
    bus.load_val = lv;
    bus.en       = e;
    bus.sw       = s;
    bus.mode     = m;
    bus.presc    = p;
  endtask

  function automatic logic [17:0] johnson_exp(input int k);
    logic [31:0] v;
    if (k <= 18) v = (32'd1 << k) - 32'd1;
    else         v = 32'h3FFFF & ~((32'd1 << (k - 18)) - 32'd1);
    return v[17:0];
  endfunction

  function automatic logic [17:0] bounce_exp(input int k);
    logic [31:0] v;
    if (k <= 17)      v = 32'd1 << k;
    else if (k <= 34) v = 32'd1 << (34 - k);
    else              v = 32'd2;
    return v[17:0];
  endfunction

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00, 8'd0);

    //          res   load  load_val   en    sw    mode   presc  exp_out    wrap  dir
    vecs[0] = '{1'b1, 1'b0, 18'h00000, 1'b0, 1'b0, 2'b00, 8'd0, 18'h00001, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 18'h00000, 1'b0, 1'b0, 2'b00, 8'd0, 18'h00001, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b1, 2'b00, 8'd0, 18'h00002, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b1, 2'b00, 8'd0, 18'h00004, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b1, 2'b00, 8'd0, 18'h00008, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 18'h2AAAA, 1'b1, 1'b1, 2'b00, 8'd0, 18'h2AAAA, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 18'h2AAAA, 1'b1, 1'b1, 2'b00, 8'd0, 18'h00001, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 2'b00, 8'd0, 18'h20000, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 2'b11, 8'd0, 18'h20000, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 2'b00, 8'd0, 18'h10000, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].res, vecs[i].load, vecs[i].load_val, vecs[i].en,
            vecs[i].sw, vecs[i].mode, vecs[i].presc);
      tick();
      check($sformatf("vec%0d out", i),  32'(bus.OUT),   32'(vecs[i].exp_out));
      check($sformatf("vec%0d wrap", i), 32'(bus.wrap),  32'(vecs[i].exp_wrap));
      check($sformatf("vec%0d dir", i),  32'(bus.dir_o), 32'(vecs[i].exp_dir));
    end

    // Reset asserted mid-sequence returns to INIT on the next edge.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 2'b00, 8'd0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 2'b00, 8'd0);
    for (int k = 0; k < 8; k++) tick();
    check("mid reset pre", 32'(bus.OUT), 32'h00100);
    res = 1'b1;
    tick();
    check("mid reset out",  32'(bus.OUT),  32'h00001);
    check("mid reset wrap", 32'(bus.wrap), 32'h0);

    // Full ring rotation left: wrap only on the step that lands on home.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 2'b00, 8'd0);
    for (int k = 1; k <= 18; k++) begin
      tick();
      check($sformatf("ringL%0d out", k),  32'(bus.OUT),  (32'd1 << (k % 18)));
      check($sformatf("ringL%0d wrap", k), 32'(bus.wrap), (k == 18) ? 32'd1 : 32'd0);
    end
    tick();
    check("ringL after wrap", 32'(bus.wrap), 32'h0);

    // Full ring rotation right from reset.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00, 8'd0);
    tick();
    res = 1'b0;
    bus.en = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check($sformatf("ringR%0d out", k),  32'(bus.OUT),  (32'd1 << (18 - k)));
      check($sformatf("ringR%0d wrap", k), 32'(bus.wrap), (k == 18) ? 32'd1 : 32'd0);
    end

    // Johnson run from an all-zero load: period 36 steps.
    drive(1'b0, 1'b1, 18'h00000, 1'b1, 1'b1, 2'b01, 8'd0);
    tick();
    check("john load", 32'(bus.OUT), 32'h0);
    bus.load = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      tick();
      check($sformatf("john%0d out", k),  32'(bus.OUT),  32'(johnson_exp(k)));
      check($sformatf("john%0d wrap", k), 32'(bus.wrap), (k == 36) ? 32'd1 : 32'd0);
    end

    // Bounce run with sw toggling every cycle after the load.
    drive(1'b0, 1'b1, 18'h00001, 1'b1, 1'b1, 2'b10, 8'd0);
    tick();
    check("bounce load dir", 32'(bus.dir_o), 32'd1);
    bus.load = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      bus.sw = k[0];
      tick();
      check($sformatf("bounce%0d out", k),  32'(bus.OUT),  32'(bounce_exp(k)));
      check($sformatf("bounce%0d dir", k),  32'(bus.dir_o),
            (k <= 17 || k == 35) ? 32'd1 : 32'd0);
      check($sformatf("bounce%0d wrap", k), 32'(bus.wrap), (k == 34) ? 32'd1 : 32'd0);
    end

    // Prescaler: presc=3 steps every 4th enabled cycle.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 2'b00, 8'd3);
    tick();
    res = 1'b0;
    bus.en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("presc c%0d", c), 32'(bus.OUT), (32'd1 << (c / 4)));
    end
    // Count is 2 here; freezing en must neither lose nor add a step.
    bus.en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("en low c%0d", c), 32'(bus.OUT), 32'h4);
    end
    bus.en = 1'b1;
    tick();
    check("resume 1", 32'(bus.OUT), 32'h4);
    tick();
    check("resume 2", 32'(bus.OUT), 32'h8);
    // Hold mode freezes pattern and count.
    bus.mode = 2'b11;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("hold c%0d", c), 32'(bus.OUT), 32'h8);
      check($sformatf("hold wrap c%0d", c), 32'(bus.wrap), 32'h0);
    end
    bus.mode = 2'b00;
    tick();
    tick();
    check("pre lower presc", 32'(bus.OUT), 32'h8);
    // Count is 2; lowering presc to 1 fires on the next enabled cycle.
    bus.presc = 8'd1;
    tick();
    check("lowered presc", 32'(bus.OUT), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
